// File: rtl/multicycle_controller_if.sv
// Handshake and control bundle between the multicycle sequencer,
// the instruction/data memories and the datapath.
interface multicycle_controller_if #(
  parameter int RET_W = 16
) ();
  logic             run;
  logic             imem_ready;
  logic [2:0]       inst;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_load;
  logic             pc_inc;
  logic             alu_op;
  logic             alu_src;
  logic             dmem_req;
  logic             dmem_we;
  logic             reg_we;
  logic             wb_sel;
  logic             busy;
  logic [1:0]       fault;
  logic [RET_W-1:0] retired;

  modport master (
    input  run, imem_ready, inst, dmem_ready,
    output imem_req, ir_load, pc_inc,
    output alu_op, alu_src,
    output dmem_req, dmem_we,
    output reg_we, wb_sel,
    output busy, fault, retired
  );

  modport slave (
    output run, imem_ready, inst, dmem_ready,
    input  imem_req, ir_load, pc_inc,
    input  alu_op, alu_src,
    input  dmem_req, dmem_we,
    input  reg_we, wb_sel,
    input  busy, fault, retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle F/D/E/M/W sequencer for the five-opcode core.
// Sticky fault on illegal opcode or memory timeout.
module multicycle_controller #(
  parameter int RET_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_controller_if.master bus
);

  localparam int WW = $clog2(MAX_WAIT) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_MEM   = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_SW   = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SLL  = 3'd4;

  localparam logic [1:0] F_ILL  = 2'd1;
  localparam logic [1:0] F_IMEM = 2'd2;
  localparam logic [1:0] F_DMEM = 2'd3;

  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [RET_W-1:0] ret_q, ret_d;
  logic [1:0]       fault_q, fault_d;
  logic             retire;
  logic             in_dp;

  // Next-state, wait counting, fault capture and retire.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    ret_d   = ret_q;
    fault_d = fault_q;
    retire  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_ready) begin
          op_d    = bus.inst;
          wait_d  = '0;
          state_d = S_DEC;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
          fault_d = F_IMEM;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DEC: begin
        if (op_q > OP_SLL) begin
          state_d = S_FAULT;
          fault_d = F_ILL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wait_d = '0;
        if (op_q == OP_SW || op_q == OP_LW)
          state_d = S_MEM;
        else
          state_d = S_WB;
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          if (op_q == OP_SW) retire = 1'b1;
          else               state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
          fault_d = F_DMEM;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_WB:    retire  = 1'b1;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (retire) begin
      ret_d   = ret_q + RET_W'(1);
      wait_d  = '0;
      state_d = bus.run ? S_FETCH : S_IDLE;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
      ret_q   <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      ret_q   <= ret_d;
      fault_q <= fault_d;
    end
  end

  assign in_dp = (state_q == S_EXEC) ||
                 (state_q == S_MEM)  ||
                 (state_q == S_WB);

  assign bus.imem_req = (state_q == S_FETCH);
  assign bus.ir_load  = bus.imem_req & bus.imem_ready;
  assign bus.pc_inc   = bus.ir_load;
  assign bus.alu_op   = in_dp & (op_q == OP_SLL);
  assign bus.alu_src  = in_dp & (op_q == OP_ADDI);
  assign bus.dmem_req = (state_q == S_MEM);
  assign bus.dmem_we  = bus.dmem_req & (op_q == OP_SW);
  assign bus.reg_we   = (state_q == S_WB);
  assign bus.wb_sel   = in_dp & (op_q == OP_LW);
  assign bus.busy     = (state_q != S_IDLE) &&
                        (state_q != S_FAULT);
  assign bus.fault    = fault_q;
  assign bus.retired  = ret_q;

endmodule
